bcd_display_ctrl: RTL and testbench

- Sequencer feeding a bank of DIGITS seven-segment decoders (one 4-bit code per HEX digit).
- Accepts an unsigned binary value through a load/busy/done handshake and converts it to BCD iteratively with shift-add-3 (double-dabble), one input bit per clock.
- Optionally blanks leading zeros, flags out-of-range values, and updates all digit codes atomically.
- Output codes use the shared decoder encoding: 0x0-0x9 digits, 0xE = "E", 0xF = blank.

---
 rtl/bcd_display_ctrl.sv | 151 +++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display sequencer.
// Accepts an unsigned binary value through a load/busy/done handshake,
// converts it with iterative shift-add-3 (one input bit per clock), optionally
// blanks leading zeros, and publishes all digit codes in a single update.
// Digit code encoding: 0x0-0x9 digits, 0xE = "E", 0xF = blank.
module bcd_display_ctrl #(
  parameter int DIGITS = 4,
  parameter int IN_W   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [IN_W-1:0]       value,
  input  logic                  blank_en,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  // Largest value that still fits on the display.
  localparam logic [IN_W-1:0] MAX_VAL = IN_W'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH,
    OVF
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [IN_W-1:0]    bin_q;    // remaining binary bits, MSB shifted out first
  logic [BCD_W-1:0]   bcd_q;    // BCD accumulator
  logic [CNT_W-1:0]   cnt_q;    // shifts still to perform
  logic               blank_q;  // blank_en captured with the accepted load

  logic [BCD_W-1:0]   bcd_adj;  // accumulator after the add-3 correction
  logic [BCD_W-1:0]   blanked;  // final digits with leading-zero blanking
  logic               lead;     // still scanning leading zeros
  logic               too_big;

  // Any non-idle state means a conversion is in flight; FINISH/OVF return
  // to IDLE on the edge that raises done, so busy is low in the done cycle.
  assign busy    = (state != IDLE);
  assign too_big = (value > MAX_VAL);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples the pre-edge values of its neighbours.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = too_big ? OVF : SHIFT;
        end
      end
      SHIFT: begin
        // The shift performed on this edge is the last one.
        if (cnt_q == CNT_W'(1)) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      OVF:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add 3 to every BCD digit that is 5 or more before it is doubled; a digit
  // of at most 9 becomes at most 12, so no carry crosses into the next digit.
  always_comb begin
    // NOTE: combinational outputs get a full default first so no path through
    // the block leaves them unassigned, which would infer a latch.
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking: from the most significant digit down, zeros turn
  // into blanks until the first nonzero digit. Digit 0 is never blanked.
  always_comb begin
    blanked = bcd_q;
    lead    = blank_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (bcd_q[4*i +: 4] == 4'h0)) begin
        blanked[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
  end

  // Conversion datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      bcd_out <= {DIGITS{4'hF}};
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            bin_q   <= value;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(IN_W);
            blank_q <= blank_en;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q - CNT_W'(1);
        end
        FINISH: begin
          bcd_out <= blanked;
          ovf     <= 1'b0;
          done    <= 1'b1;
        end
        OVF: begin
          bcd_out <= {DIGITS{4'hE}};
          ovf     <= 1'b1;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed testbench for bcd_display_ctrl (DIGITS=4, IN_W=14).
// Inputs change and outputs are observed on the falling clock edge. The
// observation point after the load edge T is counted as latency 1, so a
// result "valid at T+n" is seen at latency n.
module tb_bcd_display_ctrl;

  localparam int DIGITS = 4;
  localparam int IN_W   = 14;

  logic                clk;
  logic                rst;
  logic                load;
  logic [IN_W-1:0]     value;
  logic                blank_en;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [4*DIGITS-1:0] bcd_out;

  int compared   = 0;
  int mismatched = 0;

  bcd_display_ctrl #(
    .DIGITS (DIGITS),
    .IN_W   (IN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .blank_en (blank_en),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .bcd_out  (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference display value computed arithmetically by decimal division.
  function automatic logic [15:0] ref_bcd(input int v, input bit be);
    logic [15:0] r;
    bit          leading;
    if (v > 9999) return 16'hEEEE;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
    end
    leading = be;
    for (int i = 3; i >= 1; i--) begin
      if (leading && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else leading = 1'b0;
    end
    return r;
  endfunction

  // Called on a falling edge; returns on the falling edge after the load edge.
  task automatic start(input int v, input logic be);
    load     = 1'b1;
    value    = IN_W'(v);
    blank_en = be;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Waits (bounded) for done starting at latency k0, then checks latency,
  // busy throughout the conversion, and the published result.
  task automatic expect_result(input string tag, input int k0, input int lat,
                               input logic [15:0] exp_bcd, input logic exp_ovf);
    int k        = k0;
    int busy_low = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy before done"}, 32'(busy_low), 32'd0);
    check({tag, " bcd_out"}, 32'(bcd_out), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, " busy in done cycle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int v;
    bit be;
    int pulses;

    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset bcd_out", 32'(bcd_out), 32'hFFFF);

    // Basic conversion, busy rises right after the load edge
    start(1234, 1'b1);
    check("1234 busy at T+1", 32'(busy), 32'd1);
    expect_result("1234", 1, 16, 16'h1234, 1'b0);
    @(negedge clk);
    check("1234 done is one cycle", 32'(done), 32'd0);

    // Blanking variants and boundaries
    start(7, 1'b1);     expect_result("7 blank", 1, 16, 16'hFFF7, 1'b0);
    start(7, 1'b0);     expect_result("7 noblank", 1, 16, 16'h0007, 1'b0);
    start(0, 1'b1);     expect_result("0 blank", 1, 16, 16'hFFF0, 1'b0);
    start(0, 1'b0);     expect_result("0 noblank", 1, 16, 16'h0000, 1'b0);
    start(9999, 1'b1);  expect_result("9999", 1, 16, 16'h9999, 1'b0);
    start(10, 1'b1);    expect_result("10 blank", 1, 16, 16'hFF10, 1'b0);
    start(100, 1'b1);   expect_result("100 blank", 1, 16, 16'hF100, 1'b0);
    start(1000, 1'b1);  expect_result("1000 blank", 1, 16, 16'h1000, 1'b0);
    start(5005, 1'b1);  expect_result("5005 blank", 1, 16, 16'h5005, 1'b0);

    // Overflow path, then recovery
    start(10000, 1'b1); expect_result("10000 ovf", 1, 2, 16'hEEEE, 1'b1);
    start(16383, 1'b0); expect_result("16383 ovf", 1, 2, 16'hEEEE, 1'b1);
    start(42, 1'b1);    expect_result("42 after ovf", 1, 16, 16'hFF42, 1'b0);

    // Load while busy is ignored
    start(1234, 1'b1);
    repeat (4) @(negedge clk);          // latency 5: next edge is T+5
    load     = 1'b1;
    value    = IN_W'(5678);
    blank_en = 1'b0;
    @(negedge clk);
    load = 1'b0;
    expect_result("busy load ignored", 6, 16, 16'h1234, 1'b0);

    // Load accepted in the done cycle
    start(5678, 1'b0);
    expect_result("load in done cycle", 1, 16, 16'h5678, 1'b0);

    // Reset mid-conversion
    start(8888, 1'b1);
    repeat (7) @(negedge clk);          // latency 8: next edge is T+8
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset bcd_out", 32'(bcd_out), 32'hFFFF);
    check("midreset ovf", 32'(ovf), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    check("midreset no done", 32'(pulses), 32'd0);
    start(300, 1'b1);
    expect_result("300 after reset", 1, 16, 16'hF300, 1'b0);

    // Reset and load together: reset wins
    rst      = 1'b1;
    load     = 1'b1;
    value    = IN_W'(55);
    blank_en = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    check("rst+load busy", 32'(busy), 32'd0);
    check("rst+load bcd_out", 32'(bcd_out), 32'hFFFF);

    // Random sweep against the arithmetic reference
    for (int n = 0; n < 300; n++) begin
      v  = (n % 3 == 0) ? int'($urandom_range(99)) : int'($urandom_range(16383));
      be = 1'($urandom_range(1));
      start(v, be);
      expect_result($sformatf("sweep %0d/%0d", v, be), 1,
                    (v > 9999) ? 2 : 16, ref_bcd(v, be), (v > 9999));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
